uart_rx_mmio: RTL

//  Input-side counterpart of the CPU display path: accepts bytes from the board/simulator UART

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/uart_rx_mmio.sv | 100 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive MMIO block.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_ACK,
    RX_WAIT_LOW
  } rx_state_t;

  localparam logic [31:0] ADDR_STATUS_DEFAULT = 32'h0000_FF00;
  localparam logic [31:0] ADDR_DATA_DEFAULT   = 32'h0000_FF04;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_OVERRUN   = 8;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered occupancy count and full/empty flags.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// UART receive handshake plus FIFO, exposed to the CPU as STATUS and DATA registers.
module uart_rx_mmio
  import uart_pkg::*;
#(
  parameter int          DEPTH       = 4,
  parameter logic [31:0] ADDR_STATUS = ADDR_STATUS_DEFAULT,
  parameter logic [31:0] ADDR_DATA   = ADDR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rxdata,
  input  logic        rxready,
  output logic        rxclk,
  input  logic [31:0] addr,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        rd_hit
);

  localparam int CW = $clog2(DEPTH + 1);

  rx_state_t     state;
  rx_state_t     state_next;
  logic          push;
  logic          pop;
  logic [7:0]    head;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overrun;
  logic          hit_status;
  logic          hit_data;
  logic          status_rd;
  logic          data_rd;
  logic [31:0]   status_word;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (rxdata),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_next;
  end

  // WAIT_LOW holds off until the host drops rxready so one byte is never captured twice.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    case (state)
      RX_IDLE: begin
        if (rxready && !full) begin
          push       = 1'b1;
          state_next = RX_ACK;
        end
      end
      RX_ACK:      state_next = RX_WAIT_LOW;
      RX_WAIT_LOW: if (!rxready) state_next = RX_IDLE;
      default:     state_next = RX_IDLE;
    endcase
  end

  assign rxclk      = (state == RX_ACK);
  assign hit_status = (addr == ADDR_STATUS);
  assign hit_data   = (addr == ADDR_DATA);
  assign rd_hit     = hit_status || hit_data;
  assign status_rd  = rd_en && hit_status;
  assign data_rd    = rd_en && hit_data;
  assign pop        = data_rd && !empty;

  // Overrun is sticky: set by a DATA read on an empty FIFO, cleared by reading STATUS.
  always_ff @(posedge clk) begin
    if (rst)                     overrun <= 1'b0;
    else if (status_rd)          overrun <= 1'b0;
    else if (data_rd && empty)   overrun <= 1'b1;
  end

  always_comb begin
    status_word                        = '0;
    status_word[ST_OVERRUN]            = overrun;
    status_word[ST_COUNT_LSB +: 4]     = 4'(count);
    status_word[ST_FULL]               = full;
    status_word[ST_NOT_EMPTY]          = !empty;
  end

  always_comb begin
    rd_data = '0;
    if (status_rd)              rd_data = status_word;
    else if (data_rd && !empty) rd_data = {24'b0, head};
  end

endmodule
